// File: rtl/hvtx_timing.sv
// hvtx_timing: raster timing generator for the TMDS modulator (pixel-clock domain).
// Position counters advance on i_en; every output is registered from the decode of the next position.
module hvtx_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
   localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
   input  logic          i_pclk,
   input  logic          i_rst_n,
   input  logic          i_en,
   output logic          o_hs,
   output logic          o_vs,
   output logic          o_de,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_sol,
   output logic          o_sof
);

   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ONE  = HW'(1);
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_ONE  = VW'(1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          HS_ON  = (H_POL != 0);
   localparam logic          VS_ON  = (V_POL != 0);

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
      $error("hvtx_timing: every timing interval must be at least 1");
   end

   logic [HW-1:0] h_r;
   logic [HW-1:0] nh_s;
   logic [VW-1:0] v_r;
   logic [VW-1:0] nv_s;
   logic          de_s;
   logic          hs_s;
   logic          vs_s;
   logic          h0_s;
   logic          v0_s;

   // Next raster position: h wraps at the end of a line and carries into v.
   always_comb begin
      nh_s = h_r + H_ONE;
      nv_s = v_r;
      if (h_r == H_LAST) begin
         nh_s = {HW{1'b0}};
         if (v_r == V_LAST) begin
            nv_s = {VW{1'b0}};
         end else begin
            nv_s = v_r + V_ONE;
         end
      end else begin
         nh_s = h_r + H_ONE;
      end
   end

   // Decode of the next position; vs depends on v only, so it moves on line boundaries.
   always_comb begin
      de_s = (nh_s < H_ACT) && (nv_s < V_ACT);
      hs_s = ((nh_s >= HS_BEG) && (nh_s < HS_END)) ? HS_ON : ~HS_ON;
      vs_s = ((nv_s >= VS_BEG) && (nv_s < VS_END)) ? VS_ON : ~VS_ON;
      h0_s = (nh_s == {HW{1'b0}});
      v0_s = (nv_s == {VW{1'b0}});
   end

   // Counters and registered outputs; reset parks on the last back-porch pixel.
   always_ff @(posedge i_pclk) begin
      if (!i_rst_n) begin
         h_r   <= H_LAST;
         v_r   <= V_LAST;
         o_hs  <= ~HS_ON;
         o_vs  <= ~VS_ON;
         o_de  <= 1'b0;
         o_x   <= {XW{1'b0}};
         o_y   <= {YW{1'b0}};
         o_sol <= 1'b0;
         o_sof <= 1'b0;
      end else if (i_en) begin
         h_r   <= nh_s;
         v_r   <= nv_s;
         o_hs  <= hs_s;
         o_vs  <= vs_s;
         o_de  <= de_s;
         o_x   <= de_s ? nh_s[XW-1:0] : {XW{1'b0}};
         o_y   <= de_s ? nv_s[YW-1:0] : {YW{1'b0}};
         o_sol <= de_s & h0_s;
         o_sof <= h0_s & v0_s;
      end else begin
         o_sol <= 1'b0;
         o_sof <= 1'b0;
      end
   end

endmodule

// File: doc/hvtx_timing.md
# hvtx_timing

Raster timing generator that drives the sync, data-enable and pixel-coordinate inputs of the HDMI/TMDS modulator (`hvtx_mod`) in the pixel-clock domain. Free-running horizontal and vertical counters are decoded into registered `hs`, `vs` and `de` outputs, plus active-area coordinates and frame/line start strobes for the pixel source. Defaults give 640x480@60 (800x525 total at 25.175 MHz); all intervals are parameters.

## Interface

Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `H_POL`, 0, hsync active level (0 = active-low)
- `V_POL`, 0, vsync active level (0 = active-low)
- Derived: `H_TOTAL` = sum of H terms; `V_TOTAL` = sum of V terms; `XW` = clog2(H_ACTIVE); `YW` = clog2(V_ACTIVE)

Ports:
- `i_pclk`  in  1  pixel clock; all logic on rising edge
- `i_rst_n`  in  1  reset; one clock, synchronous, active-low
- `i_en`  in  1  pixel advance enable; 0 freezes the raster
- `o_hs`  out  1  horizontal sync, level set by `H_POL`
- `o_vs`  out  1  vertical sync, level set by `V_POL`
- `o_de`  out  1  active-video data enable
- `o_x`  out  XW  active column; 0 when `o_de`=0
- `o_y`  out  YW  active row; 0 when `o_de`=0
- `o_sol`  out  1  one-cycle strobe at position (0, v), for v < V_ACTIVE
- `o_sof`  out  1  one-cycle strobe at position (0, 0)

## Operation

- Internal position counters `h` in [0, H_TOTAL-1] and `v` in [0, V_TOTAL-1].
- When `i_en`=1 on an edge: `h` increments. At `h`=H_TOTAL-1 it wraps to 0 and `v` increments. At `v`=V_TOTAL-1 with `h` wrap, `v` wraps to 0.
- All outputs are registers loaded on the same edge as the counters from the decode of the next position. Outputs therefore always describe the current position with no combinational path from the counters.
- Decode for position (h, v):
  - `de` = h < H_ACTIVE and v < V_ACTIVE.
  - `hs` active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - `vs` active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. `vs` changes only at h=0, so it is whole-line aligned.
  - `o_x` = h and `o_y` = v when `de`=1; otherwise both are 0.
  - `o_sol` = de and h=0.
  - `o_sof` = h=0 and v=0.
- `i_en`=0: counters, `o_hs`, `o_vs`, `o_de`, `o_x` and `o_y` hold. `o_sol` and `o_sof` are forced to 0, so a strobe is asserted for exactly one enabled cycle.
- Reset (`i_rst_n`=0 at an edge) has priority over `i_en`:
  - Position loads (H_TOTAL-1, V_TOTAL-1), the last back-porch pixel.
  - Output reset values: `o_hs`=!H_POL, `o_vs`=!V_POL, `o_de`=0, `o_x`=0, `o_y`=0, `o_sol`=0, `o_sof`=0.
  - Reset asserted mid-frame aborts the frame immediately, with no partial sync completion.
- Widths: `h` and `v` use clog2(H_TOTAL) and clog2(V_TOTAL) bits. Compare constants are sized to match, with no truncation. `o_x` and `o_y` are the low XW and YW bits; their upper bits are zero by construction.
- Parameter legality (elaboration assertion): every interval >= 1.

## Timing

- First enabled edge after reset release gives position (0,0): `o_de`=1, `o_sof`=1, `o_sol`=1, `o_x`=0, `o_y`=0.
- Latency from `i_en` to output change is 1 edge.
- Line period is H_TOTAL enabled cycles. Frame period is H_TOTAL*V_TOTAL enabled cycles; the default is 420000.
- `o_hs` leading edge is H_ACTIVE+H_FP enabled cycles after `o_sol`.
- `o_vs` asserts on the edge where h=0 and v=V_ACTIVE+V_FP.
- `o_sof` and `o_sol` coincide on the first line of each frame.

## Test plan

- **Reset release:** hold `i_rst_n`=0 for 3 cycles with `i_en`=1, then release.
  - During reset: `o_de`=0, `o_hs`=1, `o_vs`=1.
  - First edge after release: `o_sof`=`o_sol`=`o_de`=1, `o_x`=0, `o_y`=0.
- **Line timing (defaults, `i_en`=1):**
  - `o_de` high 640 cycles, `o_x` ramping 0..639.
  - `o_hs` low at h=656..751 (96 cycles).
  - Next `o_sol` 800 cycles after the previous one.
- **Frame timing:**
  - `o_vs` low for exactly 1600 cycles starting at v=490, h=0.
  - `o_de` never high for v >= 480.
  - `o_sof` spacing is 420000 cycles; `o_y` reaches 479 then 0.
- **Enable gating:** drop `i_en` for 7 cycles at h=0, v=5.
  - Outputs hold; `o_sol` is high for 1 cycle only.
  - Line length measured in enabled cycles is still 800.
- **Mid-frame reset:** assert reset at v=490 (vsync active) for one cycle.
  - `o_vs` returns to 1 and `o_de` to 0 on that edge.
  - Next enabled edge produces `o_sof`.
- **Small parameters:** H=4/1/2/1, V=3/1/1/1, `H_POL`=1, `V_POL`=1.
  - Line is 8 cycles; `o_hs` is high at h=5..6.
  - Frame is 48 cycles; `o_vs` is high for line 4 only.
